// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin front end for a simple A/D/RAM
// memory datapath. One transaction at a time, fixed 4-cycle cadence:
// IDLE (accept) -> LOAD_A (A <= addr) -> ACCESS (RAM write or D <= RAM[A])
// -> RESP (one-cycle completion pulse to the requester that was served).
//
// Handshake: a request is transferred on a cycle where reqN_valid and
// reqN_ready are both high. Ready is only ever offered in IDLE, to at most
// one requester, and does not depend on anything but the valids, the
// last-served pointer and reset. Responses have no backpressure.
module mem_arbiter #(
   parameter int BUS_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req0_valid,
   input  logic                 i_req0_we,
   input  logic [BUS_WIDTH-1:0] i_req0_addr,
   input  logic [BUS_WIDTH-1:0] i_req0_wdata,
   input  logic                 i_req1_valid,
   input  logic                 i_req1_we,
   input  logic [BUS_WIDTH-1:0] i_req1_addr,
   input  logic [BUS_WIDTH-1:0] i_req1_wdata,
   output logic                 o_req0_ready,
   output logic                 o_req1_ready,
   output logic                 o_resp0_valid,
   output logic                 o_resp1_valid,
   output logic [BUS_WIDTH-1:0] o_resp_rdata,
   output logic                 o_a,
   output logic                 o_d,
   output logic                 o_p,
   output logic [BUS_WIDTH-1:0] o_X,
   input  logic [BUS_WIDTH-1:0] i_D,
   input  logic [BUS_WIDTH-1:0] i_P,
   output logic                 o_busy,
   output logic [1:0]           o_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_A = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t               state;
   state_t               next_state;
   logic [BUS_WIDTH-1:0] addr_q;
   logic [BUS_WIDTH-1:0] wdata_q;
   logic                 we_q;
   logic                 id_q;     // requester being served
   logic                 last_q;   // requester served most recently
   logic                 grant0;
   logic                 grant1;
   logic                 accept;

   // Grant: a lone valid requester wins; on a tie the one not served last wins.
   // Reset suppresses any grant so nothing is offered while it is asserted.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if ((state == IDLE) && !i_rst) begin
         if (i_req0_valid && i_req1_valid) begin
            grant0 = last_q;
            grant1 = !last_q;
         end else begin
            grant0 = i_req0_valid;
            grant1 = i_req1_valid;
         end
      end
   end

   assign accept       = grant0 | grant1;
   assign o_req0_ready = grant0;
   assign o_req1_ready = grant1;
   assign o_state      = state;

   // State register plus request capture; reset leaves requester 1 as last
   // served so requester 0 wins the first tie.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state <= next_state;
         if (accept) begin
            addr_q  <= grant1 ? i_req1_addr  : i_req0_addr;
            wdata_q <= grant1 ? i_req1_wdata : i_req0_wdata;
            we_q    <= grant1 ? i_req1_we    : i_req0_we;
            id_q    <= grant1;
            last_q  <= grant1;
         end
      end
   end

   // Next state and datapath/response outputs; everything is held at zero
   // while reset is asserted, which also keeps a pending RAM write from landing.
   always_comb begin
      next_state    = state;
      o_a           = 1'b0;
      o_d           = 1'b0;
      o_p           = 1'b0;
      o_X           = '0;
      o_resp0_valid = 1'b0;
      o_resp1_valid = 1'b0;
      o_resp_rdata  = '0;
      o_busy        = 1'b0;
      if (!i_rst) begin
         o_busy = (state != IDLE);
         case (state)
            IDLE: begin
               if (accept) next_state = LOAD_A;
            end
            LOAD_A: begin
               o_a        = 1'b1;
               o_X        = addr_q;
               next_state = ACCESS;
            end
            ACCESS: begin
               if (we_q) begin
                  o_p = 1'b1;
                  o_X = wdata_q;
               end else begin
                  o_d = 1'b1;
                  o_X = i_P;
               end
               next_state = RESP;
            end
            RESP: begin
               o_resp0_valid = !id_q;
               o_resp1_valid = id_q;
               o_resp_rdata  = we_q ? '0 : i_D;
               next_state    = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter with directed and random traffic, hosts a
// small A/D/RAM datapath, and scores every cycle against a transaction-level
// reference (arbitration rule, fixed latency, per-address memory contents).
module tb_mem_arbiter;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic         req0_valid = 1'b0, req0_we = 1'b0;
  logic         req1_valid = 1'b0, req1_we = 1'b0;
  logic [W-1:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
  logic         req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [W-1:0] resp_rdata, x_bus, d_in, p_in;
  logic         ld_a, ld_d, wr_p, busy;
  logic [1:0]   state_dbg;

  mem_arbiter #(.BUS_WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .i_req0_we(req0_we), .i_req0_addr(req0_addr), .i_req0_wdata(req0_wdata),
    .i_req1_valid(req1_valid), .i_req1_we(req1_we), .i_req1_addr(req1_addr), .i_req1_wdata(req1_wdata),
    .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
    .o_resp0_valid(resp0_valid), .o_resp1_valid(resp1_valid), .o_resp_rdata(resp_rdata),
    .o_a(ld_a), .o_d(ld_d), .o_p(wr_p), .o_X(x_bus), .i_D(d_in), .i_P(p_in),
    .o_busy(busy), .o_state(state_dbg)
  );

  // ---------------- memory datapath (not cleared by reset) ----------------
  logic [W-1:0] a_reg = '0, d_reg = '0;
  logic [W-1:0] ram [256];
  always @(posedge clk) begin
    if (ld_a) a_reg <= x_bus;
    if (ld_d) d_reg <= x_bus;
    if (wr_p) ram[a_reg] <= x_bus;
  end
  assign d_in = d_reg;
  assign p_in = ram[a_reg];

  // ---------------- scoreboard state ----------------
  typedef struct {
    bit           id;
    logic [W-1:0] rdata;
    int           due;
  } resp_t;
  resp_t        exp_q[$];
  logic [W-1:0] ref_mem [256];
  int           errors = 0;
  int           checks = 0;

  // transaction-level reference: one transaction occupies 4 cycles from acceptance
  int           t_acc = -1;
  bit           last_served = 1'b1;
  bit           t_we;
  logic [W-1:0] t_addr, t_wdata, t_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // reference model: expected grant, datapath controls, X bus; pushes responses
  always @(negedge clk) begin
    bit   idle;
    logic g0, g1;
    int   ph;
    logic [3:0]   ex_ctl;
    logic [W-1:0] ex_x;
    if (rst) begin
      check("reset_ctl", {req0_ready, req1_ready, resp0_valid, resp1_valid, ld_a, ld_d, wr_p, busy}, 0);
      check("reset_bus", {x_bus, resp_rdata}, 0);
      t_acc = -1;
      last_served = 1'b1;
      exp_q.delete();
    end else begin
      idle = (t_acc < 0) || (cyc >= t_acc + 4);
      ph = idle ? 0 : cyc - t_acc;
      g0 = 1'b0;
      g1 = 1'b0;
      if (idle) begin
        if (req0_valid && req1_valid) begin
          g0 = last_served;
          g1 = !last_served;
        end else begin
          g0 = req0_valid;
          g1 = req1_valid;
        end
      end
      check("ready", {req0_ready, req1_ready}, {g0, g1});
      ex_ctl = 4'b0000;  // {a, d, p, busy}
      ex_x   = '0;
      if (ph == 1) begin
        ex_ctl = 4'b1001;
        ex_x   = t_addr;
      end else if (ph == 2) begin
        ex_ctl = t_we ? 4'b0011 : 4'b0101;
        ex_x   = t_we ? t_wdata : t_rd;
      end else if (ph == 3) begin
        ex_ctl = 4'b0001;
      end
      check("ctl", {ld_a, ld_d, wr_p, busy}, ex_ctl);
      check("x_bus", x_bus, ex_x);
      check("ctl_onehot", ($countones({ld_a, ld_d, wr_p}) <= 1), 1);
      if (ph == 2 && t_we) ref_mem[t_addr] = t_wdata;
      if (g0 || g1) begin
        t_acc       = cyc;
        last_served = g1;
        t_we        = g1 ? req1_we : req0_we;
        t_addr      = g1 ? req1_addr : req0_addr;
        t_wdata     = g1 ? req1_wdata : req0_wdata;
        t_rd        = t_we ? '0 : ref_mem[t_addr];
        exp_q.push_back('{id: g1, rdata: t_rd, due: cyc + 3});
      end
    end
  end

  // monitor: pops the expected queue whenever the DUT presents a response
  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      if (resp0_valid || resp1_valid) begin
        check("resp_single", resp0_valid & resp1_valid, 0);
        if (exp_q.size() == 0) begin
          check("resp_unexpected", resp0_valid | resp1_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("resp_id", resp1_valid, e.id);
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_cycle", cyc, e.due);
        end
      end else begin
        check("rdata_idle", resp_rdata, 0);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          check("resp_missing", resp0_valid | resp1_valid, 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // present up to two requests and hold each until it is accepted
  task automatic issue(input logic v0, input logic we0, input logic [W-1:0] a0, input logic [W-1:0] d0,
                       input logic v1, input logic we1, input logic [W-1:0] a1, input logic [W-1:0] d1);
    logic p0, p1;
    int   n;
    p0 = v0;
    p1 = v1;
    n  = 0;
    @(posedge clk);
    #1;
    req0_we = we0; req0_addr = a0; req0_wdata = d0; req0_valid = p0;
    req1_we = we1; req1_addr = a1; req1_wdata = d1; req1_valid = p1;
    while ((p0 || p1) && n < 40) begin
      @(negedge clk);
      if (req0_ready) p0 = 1'b0;
      if (req1_ready) p1 = 1'b0;
      @(posedge clk);
      #1;
      req0_valid = p0;
      req1_valid = p1;
      n++;
    end
    check("accept_timeout", {p0, p1}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = W'(i * 13 + 7);
      ref_mem[i] = W'(i * 13 + 7);
    end
    ram[8'h20] = 8'h3C; ref_mem[8'h20] = 8'h3C;
    ram[8'h21] = 8'h7E; ref_mem[8'h21] = 8'h7E;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // write then read back through requester 0
    issue(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
    idle_cycles(4);
    issue(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    idle_cycles(6);

    // tie immediately after reset: requester 0 first
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    issue(1'b1, 1'b0, 8'h21, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    idle_cycles(6);

    // both requesters kept busy for 8 transactions
    for (int k = 0; k < 4; k++)
      issue(1'b1, 1'(k % 2), W'($urandom_range(0, 15)), W'($urandom),
            1'b1, 1'((k + 1) % 2), W'($urandom_range(0, 15)), W'($urandom));
    idle_cycles(6);

    // reset during ACCESS of a write: no response, write abandoned
    issue(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 8'hFF);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(10);
    issue(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00);
    idle_cycles(6);

    // random traffic with occasional resets
    repeat (1000) begin
      @(posedge clk);
      #1;
      rst        = ($urandom_range(0, 199) == 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req0_we    = 1'($urandom_range(0, 1));
      req0_addr  = W'($urandom_range(0, 15));
      req0_wdata = W'($urandom);
      req1_valid = ($urandom_range(0, 2) != 0);
      req1_we    = 1'($urandom_range(0, 1));
      req1_addr  = W'($urandom_range(0, 15));
      req1_wdata = W'($urandom);
    end
    rst = 1'b0;
    idle_cycles(10);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, width of data, address and the shared X bus.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports i_req0_valid / i_req1_valid  input  1  request valid, one per requester.
REQ-005 SHALL have ports i_req0_we / i_req1_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports i_req0_addr / i_req1_addr  input  BUS_WIDTH  memory address.
REQ-007 SHALL have ports i_req0_wdata / i_req1_wdata  input  BUS_WIDTH  write data.
REQ-008 SHALL have ports o_req0_ready / o_req1_ready  output  1  request accepted this cycle.
REQ-009 SHALL have ports o_resp0_valid / o_resp1_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port o_resp_rdata  output  BUS_WIDTH  read data, qualified by either resp valid.
REQ-011 SHALL have ports o_a, o_d, o_p  output  1  load enables for the A register, D register and RAM write of the memory datapath.
REQ-012 SHALL have port o_X  output  BUS_WIDTH  shared X bus into the datapath.
REQ-013 SHALL have ports i_D, i_P  input  BUS_WIDTH  D register value and RAM read data at address A, from the datapath.
REQ-014 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD_A, ACCESS, RESP; IDLE->LOAD_A on accepted request, LOAD_A->ACCESS, ACCESS->RESP, RESP->IDLE unconditionally.
REQ-016 SHALL, in IDLE, assert o_reqN_ready combinationally for exactly one valid requester (the grant) and for none if neither is valid; ready SHALL be 0 outside IDLE.
REQ-017 SHALL grant requester N when only N is valid; when both are valid, SHALL grant the requester not served last (round robin).
REQ-018 SHALL, on acceptance (valid && ready), latch addr, wdata, we and requester id, and update the last-served pointer.
REQ-019 SHALL, in LOAD_A, drive o_a=1, o_X=latched addr, o_d=o_p=0.
REQ-020 SHALL, in ACCESS for a write, drive o_p=1, o_X=latched wdata, o_a=o_d=0.
REQ-021 SHALL, in ACCESS for a read, drive o_d=1, o_X=i_P, o_a=o_p=0.
REQ-022 SHALL, in RESP, pulse o_respN_valid for the latched requester only, for exactly one cycle; o_resp_rdata SHALL equal i_D for a read and 0 for a write.
REQ-023 SHALL drive o_a=o_d=o_p=0 and o_X=0 in IDLE and RESP; o_resp_rdata SHALL be 0 whenever no resp valid is high.
REQ-024 SHALL never assert more than one of o_a, o_d, o_p in a cycle.
REQ-025 SHALL give a fixed latency: acceptance in cycle T, resp valid in cycle T+3; peak throughput one transaction per 4 cycles.
REQ-026 SHALL ignore valid changes and request fields outside IDLE; new requests wait, with ready low.
REQ-027 SHALL have no response backpressure; a requester SHALL not stall the pulse.

Reset
REQ-028 SHALL, while i_rst=1 at a clock edge, enter IDLE, clear latched fields, and set the last-served pointer to requester 1, so requester 0 wins the first tie.
REQ-029 SHALL hold all outputs at 0 during and after reset until a request is accepted.
REQ-030 SHALL, on reset mid-transaction, abandon it with no response pulse; a RAM write already committed by o_p SHALL stand, and RAM contents SHALL not be cleared.

Verification
REQ-031 Write then read: req0 write addr 0x10 data 0xA5, then req0 read 0x10 -> o_p=1 with o_X=0xA5 in cycle T+2; resp0 pulses; read resp rdata=0xA5 at T+3.
REQ-032 Tie after reset: both valid, req1 read 0x20 (mem 0x3C) and req0 read 0x21 (mem 0x7E) -> req0 granted first (0x7E), req1 next (0x3C), resp order 0 then 1.
REQ-033 Fairness: both held valid for 8 transactions -> grants alternate 0,1,0,1...; each resp at acceptance+3; ready low in all non-IDLE cycles.
REQ-034 Reset in ACCESS: req1 write 0x05 data 0xFF, i_rst in ACCESS cycle -> no resp1 pulse, outputs 0 next cycle, FSM IDLE.
REQ-035 Idle behaviour: no valids for 10 cycles -> ready, resp, o_a/o_d/o_p, o_X and o_busy all 0.
REQ-036 Control invariant: random traffic 1000 cycles -> at most one of o_a/o_d/o_p high; scoreboard read data matches last write per address.
